store_queue: RTL and testbench

- Parametrised successor to the memory unit's fixed 4-entry store buffer, for the fcpu out-of-order core.
- Holds dispatched stores in program order and snoops the CDB for pending store data.
- Accepts computed addresses from the address stage and marks entries committed on ROB retire.
- Answers age-qualified load queries (forward / stall / miss) and drains committed stores to the memory port with a valid/ready handshake.

---
 rtl/store_queue_pkg.sv | 29 ++
 rtl/store_queue_if.sv | 56 +++++
 rtl/store_queue_age_match.sv | 46 ++++
 rtl/store_queue.sv | 165 ++++++++++++++++
 tb/tb_store_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/store_queue_pkg.sv
// rtl/store_queue_pkg.sv - shared widths, store entry type and opcode helper for the store queue
package store_queue_pkg;

  localparam int SQ_DEPTH  = 8;
  localparam int SQ_DATA_W = 32;
  localparam int RSV_ID_W  = 5;
  localparam int INSTR_W   = 6;

  localparam logic [INSTR_W-1:0] OP_SB = 6'h28;
  localparam logic [INSTR_W-1:0] OP_SH = 6'h29;
  localparam logic [INSTR_W-1:0] OP_SW = 6'h2B;

  typedef struct packed {
    logic                 valid;
    logic [RSV_ID_W-1:0]  id;
    logic [INSTR_W-1:0]   op;
    logic [SQ_DATA_W-1:0] data;
    logic                 data_rdy;
    logic [RSV_ID_W-1:0]  data_tag;
    logic [SQ_DATA_W-1:0] addr;
    logic                 addr_rdy;
    logic                 committed;
  } sq_entry_t;

  function automatic logic is_store(input logic [INSTR_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/store_queue_if.sv
// rtl/store_queue_if.sv - dispatch, address, CDB, commit, load-query and drain signals of the store queue
interface store_queue_if #(
  parameter int DEPTH  = store_queue_pkg::SQ_DEPTH,
  parameter int DATA_W = store_queue_pkg::SQ_DATA_W,
  parameter int ID_W   = store_queue_pkg::RSV_ID_W,
  parameter int OP_W   = store_queue_pkg::INSTR_W
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CDB_W = ID_W + DATA_W;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [ID_W-1:0]   alloc_id;
  logic [OP_W-1:0]   alloc_op;
  logic [DATA_W-1:0] alloc_data;
  logic              alloc_data_rdy;
  logic [ID_W-1:0]   alloc_data_tag;
  logic [PTR_W:0]    alloc_pos;
  logic              addr_valid;
  logic [ID_W-1:0]   addr_id;
  logic [DATA_W-1:0] addr_value;
  logic              cdb_valid;
  logic [CDB_W-1:0]  cdb;
  logic              commit_valid;
  logic [ID_W-1:0]   commit_id;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_addr;
  logic [PTR_W:0]    ld_pos;
  logic              ld_fwd;
  logic [DATA_W-1:0] ld_fwd_data;
  logic              ld_stall;
  logic              ld_miss;
  logic              drain_valid;
  logic [ID_W-1:0]   drain_id;
  logic [OP_W-1:0]   drain_op;
  logic [DATA_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic              drain_ready;

  modport master (
    output alloc_valid, alloc_id, alloc_op, alloc_data, alloc_data_rdy, alloc_data_tag,
           addr_valid, addr_id, addr_value, cdb_valid, cdb, commit_valid, commit_id,
           ld_valid, ld_addr, ld_pos, drain_ready,
    input  alloc_ready, alloc_pos, ld_fwd, ld_fwd_data, ld_stall, ld_miss,
           drain_valid, drain_id, drain_op, drain_addr, drain_data
  );

  modport slave (
    input  alloc_valid, alloc_id, alloc_op, alloc_data, alloc_data_rdy, alloc_data_tag,
           addr_valid, addr_id, addr_value, cdb_valid, cdb, commit_valid, commit_id,
           ld_valid, ld_addr, ld_pos, drain_ready,
    output alloc_ready, alloc_pos, ld_fwd, ld_fwd_data, ld_stall, ld_miss,
           drain_valid, drain_id, drain_op, drain_addr, drain_data
  );

endinterface

// File: rtl/store_queue_age_match.sv
// rtl/store_queue_age_match.sv - youngest-older store search for load queries
// Walks from head towards ld_pos; later hits overwrite earlier ones so the youngest match wins.
module store_queue_age_match #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             ld_valid_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] addr_rdy_i,
  input  logic [DEPTH-1:0] data_rdy_i,
  input  logic [DEPTH-1:0] match_i,
  input  logic [PTR_W:0]   head_i,
  input  logic [PTR_W:0]   ld_pos_i,
  output logic [PTR_W-1:0] match_idx_o,
  output logic             fwd_o,
  output logic             stall_o,
  output logic             miss_o
);
  logic [PTR_W:0]   older_cnt;
  logic [PTR_W-1:0] idx;
  logic             hit;
  logic             pending;

  always_comb begin
    older_cnt   = ld_pos_i - head_i;
    idx         = '0;
    hit         = 1'b0;
    pending     = 1'b0;
    match_idx_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i[PTR_W-1:0] + PTR_W'(k);
      if (((PTR_W+1)'(k) < older_cnt) && valid_i[idx]) begin
        if (!addr_rdy_i[idx]) begin
          pending = 1'b1;
        end else if (match_i[idx]) begin
          hit         = 1'b1;
          match_idx_o = idx;
        end
      end
    end
    fwd_o   = ld_valid_i & !pending & hit & data_rdy_i[match_idx_o];
    stall_o = ld_valid_i & (pending | (hit & !data_rdy_i[match_idx_o]));
    miss_o  = ld_valid_i & !pending & !hit;
  end

endmodule

// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue with CDB snoop, age-qualified load forwarding and commit drain
// Optional flush of uncommitted entries: STORE_QUEUE_FLUSH_EN
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH  = SQ_DEPTH,
  parameter int DATA_W = SQ_DATA_W,
  parameter int ID_W   = RSV_ID_W,
  parameter int OP_W   = INSTR_W
) (
  input logic          clk,
  input logic          nrst,
`ifdef STORE_QUEUE_FLUSH_EN
  input logic          flush,
`endif
  store_queue_if.slave sq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CDB_W = ID_W + DATA_W;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
    logic              data_rdy;
    logic [ID_W-1:0]   data_tag;
    logic [DATA_W-1:0] addr;
    logic              addr_rdy;
    logic              committed;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            ent_d [DEPTH];
  entry_t            head_e;
  logic [PTR_W:0]    head_q, head_d, tail_q, tail_d;
  logic              full, push, pop, drain_ok, cdb_at_alloc;
  logic [ID_W-1:0]   cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [DEPTH-1:0]  valid_vec, addr_rdy_vec, data_rdy_vec, match_vec;
  logic [PTR_W-1:0]  match_idx;
  logic              ld_fwd;
`ifdef STORE_QUEUE_FLUSH_EN
  logic [PTR_W:0]    keep_cnt;
  logic              keep_run;
  logic [PTR_W-1:0]  fidx;
`endif

  assign cdb_tag      = sq.cdb[CDB_W-1:DATA_W];
  assign cdb_data     = sq.cdb[DATA_W-1:0];
  assign full         = (head_q[PTR_W] != tail_q[PTR_W]) && (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign head_e       = ent_q[head_q[PTR_W-1:0]];
  assign drain_ok     = head_e.valid & head_e.committed & head_e.addr_rdy & head_e.data_rdy;
  assign pop          = drain_ok & sq.drain_ready;
  assign cdb_at_alloc = sq.cdb_valid && !sq.alloc_data_rdy && (cdb_tag == sq.alloc_data_tag);
`ifdef STORE_QUEUE_FLUSH_EN
  assign push = sq.alloc_valid & !full & !flush;
`else
  assign push = sq.alloc_valid & !full;
`endif

  assign sq.alloc_ready = !full;
  assign sq.alloc_pos   = tail_q;
  assign sq.drain_valid = drain_ok;
  assign sq.drain_id    = head_e.id;
  assign sq.drain_op    = head_e.op;
  assign sq.drain_addr  = head_e.addr;
  assign sq.drain_data  = head_e.data;

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (sq.cdb_valid && !ent_q[i].data_rdy && (ent_q[i].data_tag == cdb_tag)) begin
          ent_d[i].data     = cdb_data;
          ent_d[i].data_rdy = 1'b1;
        end
        if (sq.addr_valid && (ent_q[i].id == sq.addr_id)) begin
          ent_d[i].addr     = sq.addr_value;
          ent_d[i].addr_rdy = 1'b1;
        end
        if (sq.commit_valid && (ent_q[i].id == sq.commit_id)) begin
          ent_d[i].committed = 1'b1;
        end
      end
    end
`ifdef STORE_QUEUE_FLUSH_EN
    // Commits retire in order, so surviving entries form a contiguous run from head.
    keep_cnt = '0;
    keep_run = 1'b1;
    fidx     = '0;
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        fidx = head_q[PTR_W-1:0] + PTR_W'(k);
        if (keep_run && ent_d[fidx].valid && ent_d[fidx].committed) begin
          keep_cnt = keep_cnt + 1'b1;
        end else begin
          keep_run = 1'b0;
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (!ent_d[i].committed) ent_d[i] = '0;
      end
      tail_d = head_q + keep_cnt;
    end
`endif
    if (pop) begin
      ent_d[head_q[PTR_W-1:0]] = '0;
      head_d = head_q + 1'b1;
    end
    if (push) begin
      ent_d[tail_q[PTR_W-1:0]] = '{valid: 1'b1, id: sq.alloc_id, op: sq.alloc_op,
                                   data: cdb_at_alloc ? cdb_data : sq.alloc_data,
                                   data_rdy: sq.alloc_data_rdy | cdb_at_alloc,
                                   data_tag: sq.alloc_data_tag, addr: '0,
                                   addr_rdy: 1'b0, committed: 1'b0};
      tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

  always_comb begin
    valid_vec    = '0;
    addr_rdy_vec = '0;
    data_rdy_vec = '0;
    match_vec    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i]    = ent_q[i].valid;
      addr_rdy_vec[i] = ent_q[i].addr_rdy;
      data_rdy_vec[i] = ent_q[i].data_rdy;
      match_vec[i]    = (ent_q[i].addr == sq.ld_addr);
    end
  end

  store_queue_age_match #(.DEPTH(DEPTH)) u_age_match (
    .ld_valid_i  (sq.ld_valid),
    .valid_i     (valid_vec),
    .addr_rdy_i  (addr_rdy_vec),
    .data_rdy_i  (data_rdy_vec),
    .match_i     (match_vec),
    .head_i      (head_q),
    .ld_pos_i    (sq.ld_pos),
    .match_idx_o (match_idx),
    .fwd_o       (ld_fwd),
    .stall_o     (sq.ld_stall),
    .miss_o      (sq.ld_miss)
  );

  assign sq.ld_fwd      = ld_fwd;
  assign sq.ld_fwd_data = ld_fwd ? ent_q[match_idx].data : '0;

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue (flush section under STORE_QUEUE_FLUSH_EN)
module tb_store_queue;
  import store_queue_pkg::*;

  localparam logic [2:0] R_FWD = 3'b100;
  localparam logic [2:0] R_STL = 3'b010;
  localparam logic [2:0] R_MIS = 3'b001;

  logic        clk = 1'b0;
  logic        nrst;
`ifdef STORE_QUEUE_FLUSH_EN
  logic        flush;
`endif
  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  ld_res;
  logic [31:0] ld_data;
  logic [4:0]  ids5 [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};

  store_queue_if sq ();

  store_queue dut (
    .clk   (clk),
    .nrst  (nrst),
`ifdef STORE_QUEUE_FLUSH_EN
    .flush (flush),
`endif
    .sq    (sq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sq.alloc_valid = 1'b0; sq.alloc_id = '0; sq.alloc_op = '0; sq.alloc_data = '0;
    sq.alloc_data_rdy = 1'b0; sq.alloc_data_tag = '0;
    sq.addr_valid = 1'b0; sq.addr_id = '0; sq.addr_value = '0;
    sq.cdb_valid = 1'b0; sq.cdb = '0; sq.commit_valid = 1'b0; sq.commit_id = '0;
    sq.ld_valid = 1'b0; sq.ld_addr = '0; sq.ld_pos = '0; sq.drain_ready = 1'b0;
  endtask

  task automatic do_alloc(input logic [4:0] id, input logic [31:0] data, input logic rdy, input logic [4:0] tag);
    sq.alloc_valid = 1'b1; sq.alloc_id = id; sq.alloc_op = OP_SW;
    sq.alloc_data = data; sq.alloc_data_rdy = rdy; sq.alloc_data_tag = tag;
    tick();
    sq.alloc_valid = 1'b0;
  endtask

  task automatic do_addr(input logic [4:0] id, input logic [31:0] a);
    sq.addr_valid = 1'b1; sq.addr_id = id; sq.addr_value = a;
    tick();
    sq.addr_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [4:0] id);
    sq.commit_valid = 1'b1; sq.commit_id = id;
    tick();
    sq.commit_valid = 1'b0;
  endtask

  task automatic do_cdb(input logic [4:0] tag, input logic [31:0] data);
    sq.cdb_valid = 1'b1; sq.cdb = {tag, data};
    tick();
    sq.cdb_valid = 1'b0;
  endtask

  task automatic expect_ld(input string tag, input logic [31:0] a, input logic [3:0] pos,
                           input logic [2:0] res_exp, input logic [31:0] data_exp);
    sq.ld_valid = 1'b1; sq.ld_addr = a; sq.ld_pos = pos;
    #1;
    ld_res  = {sq.ld_fwd, sq.ld_stall, sq.ld_miss};
    ld_data = sq.ld_fwd_data;
    sq.ld_valid = 1'b0;
    check(tag, 64'(ld_res), 64'(res_exp));
    if (res_exp == R_FWD) check({tag, "_data"}, 64'(ld_data), 64'(data_exp));
  endtask

  initial begin
    idle();
    nrst = 1'b1;
`ifdef STORE_QUEUE_FLUSH_EN
    flush = 1'b0;
`endif
    tick();
    tick();
    nrst = 1'b0;
    check("rst_alloc_ready", 64'(sq.alloc_ready), 64'd1);
    check("rst_alloc_pos", 64'(sq.alloc_pos), 64'd0);
    check("rst_drain_valid", 64'(sq.drain_valid), 64'd0);
    check("rst_drain_addr", 64'(sq.drain_addr), 64'd0);
    check("rst_ld_flags", 64'({sq.ld_fwd, sq.ld_stall, sq.ld_miss}), 64'd0);

    // fill, full behaviour, in-order drain
    for (int i = 0; i < 8; i++) begin
      check("fill_ready", 64'(sq.alloc_ready), 64'd1);
      do_alloc(5'(i), 32'h1000 + 32'(i), 1'b1, 5'd0);
    end
    check("full_ready", 64'(sq.alloc_ready), 64'd0);
    check("full_pos", 64'(sq.alloc_pos), 64'd8);
    do_alloc(5'd15, 32'hBAD, 1'b1, 5'd0);
    check("full_alloc_ignored", 64'(sq.alloc_pos), 64'd8);
    for (int i = 0; i < 8; i++) do_addr(5'(i), 32'h100 + 32'(4 * i));
    for (int i = 0; i < 8; i++) do_commit(5'(i));
    check("hold_drain_valid", 64'(sq.drain_valid), 64'd1);
    check("hold_drain_addr", 64'(sq.drain_addr), 64'h100);
    check("hold_drain_op", 64'(sq.drain_op), 64'(OP_SW));
    sq.drain_ready = 1'b1;
    sq.alloc_valid = 1'b1;
    sq.alloc_id    = 5'd15;
    tick();
    sq.alloc_valid = 1'b0;
    check("pop_only_pos", 64'(sq.alloc_pos), 64'd8);
    check("pop_ready", 64'(sq.alloc_ready), 64'd1);
    for (int i = 1; i < 8; i++) begin
      check("drain_valid", 64'(sq.drain_valid), 64'd1);
      check("drain_addr", 64'(sq.drain_addr), 64'(32'h100 + 32'(4 * i)));
      check("drain_data", 64'(sq.drain_data), 64'(32'h1000 + 32'(i)));
      tick();
    end
    sq.drain_ready = 1'b0;
    check("empty_drain_valid", 64'(sq.drain_valid), 64'd0);

    // youngest older store wins; age window follows ld_pos
    do_alloc(5'd1, 32'hA, 1'b1, 5'd0);
    do_alloc(5'd2, 32'hB, 1'b1, 5'd0);
    do_addr(5'd1, 32'h40);
    do_addr(5'd2, 32'h40);
    expect_ld("fwd_youngest", 32'h40, 4'd10, R_FWD, 32'hB);
    expect_ld("fwd_older_only", 32'h40, 4'd9, R_FWD, 32'hA);
    expect_ld("older_empty", 32'h40, 4'd8, R_MIS, 32'h0);
    do_alloc(5'd3, 32'h33, 1'b1, 5'd0);
    expect_ld("stall_addr_pending", 32'h84, 4'd11, R_STL, 32'h0);
    do_addr(5'd3, 32'h80);
    expect_ld("miss_after_addr", 32'h84, 4'd11, R_MIS, 32'h0);
    expect_ld("fwd_after_addr", 32'h80, 4'd11, R_FWD, 32'h33);

    // CDB capture in the allocation cycle and two cycles later
    sq.cdb_valid = 1'b1;
    sq.cdb       = {5'd5, 32'hDEAD};
    do_alloc(5'd4, 32'h0, 1'b0, 5'd5);
    sq.cdb_valid = 1'b0;
    do_addr(5'd4, 32'h200);
    expect_ld("cdb_same_cycle", 32'h200, 4'd12, R_FWD, 32'hDEAD);
    do_alloc(5'd6, 32'h0, 1'b0, 5'd5);
    do_addr(5'd6, 32'h300);
    expect_ld("data_pending_stall", 32'h300, 4'd13, R_STL, 32'h0);
    tick();
    do_cdb(5'd5, 32'hDEAD);
    expect_ld("cdb_later", 32'h300, 4'd13, R_FWD, 32'hDEAD);
    for (int i = 0; i < 5; i++) do_commit(ids5[i]);
    sq.drain_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain5_id", 64'(sq.drain_id), 64'(ids5[i]));
      tick();
    end
    sq.drain_ready = 1'b0;
    check("drain5_empty", 64'(sq.drain_valid), 64'd0);
    check("drain5_pos", 64'(sq.alloc_pos), 64'd13);

    // pointer wrap
    for (int k = 0; k < 8; k++) do_alloc(5'(16 + k), 32'h5000 + 32'(k), 1'b1, 5'd0);
    check("wrap_full_ready", 64'(sq.alloc_ready), 64'd0);
    check("wrap_full_pos", 64'(sq.alloc_pos), 64'd5);
    for (int k = 0; k < 8; k++) do_addr(5'(16 + k), 32'h500 + 32'(4 * k));
    for (int k = 0; k < 8; k++) do_commit(5'(16 + k));
    sq.drain_ready = 1'b1;
    repeat (3) tick();
    sq.drain_ready = 1'b0;
    for (int j = 0; j < 3; j++) do_alloc(5'(24 + j), 32'h6000 + 32'(j), 1'b1, 5'd0);
    check("wrap_refull_ready", 64'(sq.alloc_ready), 64'd0);
    check("wrap_refull_pos", 64'(sq.alloc_pos), 64'd8);
    for (int j = 0; j < 3; j++) do_addr(5'(24 + j), 32'h600 + 32'(4 * j));
    expect_ld("wrap_pos_eq_head", 32'h50C, 4'd0, R_MIS, 32'h0);
    expect_ld("wrap_fwd", 32'h50C, 4'd8, R_FWD, 32'h5003);
    expect_ld("wrap_no_false_match", 32'h510, 4'd1, R_MIS, 32'h0);
    for (int j = 0; j < 3; j++) do_commit(5'(24 + j));
    sq.drain_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("wrap_drain_id", 64'(sq.drain_id), 64'(19 + i));
      tick();
    end
    sq.drain_ready = 1'b0;
    check("wrap_empty", 64'(sq.drain_valid), 64'd0);

`ifdef STORE_QUEUE_FLUSH_EN
    for (int i = 0; i < 5; i++) do_alloc(5'(i + 1), 32'h70 + 32'(i), 1'b1, 5'd0);
    for (int i = 0; i < 5; i++) do_addr(5'(i + 1), 32'h700 + 32'(4 * i));
    do_commit(5'd1);
    do_commit(5'd2);
    flush          = 1'b1;
    sq.alloc_valid = 1'b1;
    sq.alloc_id    = 5'd9;
    tick();
    flush          = 1'b0;
    sq.alloc_valid = 1'b0;
    check("flush_tail", 64'(sq.alloc_pos), 64'd10);
    sq.drain_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("flush_drain_valid", 64'(sq.drain_valid), 64'd1);
      check("flush_drain_id", 64'(sq.drain_id), 64'(i + 1));
      tick();
    end
    check("flush_rest_cleared", 64'(sq.drain_valid), 64'd0);
    sq.drain_ready = 1'b0;
    do_alloc(5'd7, 32'h77, 1'b1, 5'd0);
    check("flush_next_pos", 64'(sq.alloc_pos), 64'd11);
    do_addr(5'd7, 32'h7F0);
    do_commit(5'd7);
    check("flush_next_head_id", 64'(sq.drain_id), 64'd7);
    check("flush_next_head_addr", 64'(sq.drain_addr), 64'h7F0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
